alu_operand_loader: RTL and testbench

Upstream input stage for the lab ALU. It debounces a single raw push-button and uses it to capture the shared data switches, one press at a time, into a held operand A, a held operand B and a held opcode. It then flags the set as valid. Its A, B and op outputs drive the ALU top directly, so one bank of board switches can supply both operands and the operation.

---
 rtl/alu_operand_loader.sv | 133 +++++++++++++
 tb/tb_alu_operand_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures operand A, operand B and the opcode from the shared
// switches, one debounced button press at a time, and holds them as a validated set.
module alu_operand_loader #(
   parameter int W         = 4,
   parameter int DB_CYCLES = 250000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] data_sw,
   input  logic [3:0]   op_sw,
   input  logic         btn_load,
   input  logic         btn_clear,
   output logic [W-1:0] A,
   output logic [W-1:0] B,
   output logic [3:0]   op,
   output logic         valid,
   output logic         loaded,
   output logic [1:0]   state_o
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'b00,
      LOAD_B  = 2'b01,
      LOAD_OP = 2'b10,
      READY   = 2'b11
   } state_t;

   state_t        state, state_nxt;
   logic          load_s1, load_s2, clr_s1, clr_s2;
   logic          db, press, flip;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_nxt, b_nxt;
   logic [3:0]    op_nxt;
   logic          valid_nxt, loaded_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_s1 <= 1'b0;
         load_s2 <= 1'b0;
         clr_s1  <= 1'b0;
         clr_s2  <= 1'b0;
      end else begin
         load_s1 <= btn_load;
         load_s2 <= load_s1;
         clr_s1  <= btn_clear;
         clr_s2  <= clr_s1;
      end
   end

   // The edge that completes DB_CYCLES consecutive mismatches is the one that flips db.
   assign flip = (load_s2 != db) && (cnt == CW'(DB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db    <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= flip & ~db;
         if (flip) begin
            db  <= ~db;
            cnt <= '0;
         end else if (load_s2 != db) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= LOAD_A;
         A      <= '0;
         B      <= '0;
         op     <= '0;
         valid  <= 1'b0;
         loaded <= 1'b0;
      end else begin
         state  <= state_nxt;
         A      <= a_nxt;
         B      <= b_nxt;
         op     <= op_nxt;
         valid  <= valid_nxt;
         loaded <= loaded_nxt;
      end
   end

   // Clear outranks a press arriving in the same cycle, so that press is simply lost.
   always_comb begin
      state_nxt  = state;
      a_nxt      = A;
      b_nxt      = B;
      op_nxt     = op;
      valid_nxt  = valid;
      loaded_nxt = 1'b0;
      if (clr_s2) begin
         state_nxt = LOAD_A;
         a_nxt     = '0;
         b_nxt     = '0;
         op_nxt    = '0;
         valid_nxt = 1'b0;
      end else if (press) begin
         case (state)
            LOAD_A: begin
               a_nxt     = data_sw;
               state_nxt = LOAD_B;
            end
            LOAD_B: begin
               b_nxt     = data_sw;
               state_nxt = LOAD_OP;
            end
            LOAD_OP: begin
               op_nxt     = op_sw;
               state_nxt  = READY;
               valid_nxt  = 1'b1;
               loaded_nxt = 1'b1;
            end
            READY: begin
               a_nxt     = data_sw;
               valid_nxt = 1'b0;
               state_nxt = LOAD_B;
            end
            default: state_nxt = LOAD_A;
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: a table of press/clear records, hand-timed corner
// sequences, and random button activity checked every cycle against a reference model.
module tb_alu_operand_loader;

   localparam int W   = 4;
   localparam int DBC = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] data_sw = '0;
   logic [3:0]   op_sw = '0;
   logic         btn_load = 1'b0;
   logic         btn_clear = 1'b0;
   logic [W-1:0] A, B;
   logic [3:0]   op;
   logic         valid, loaded;
   logic [1:0]   state_o;

   int vectors = 0;
   int miscompares = 0;
   int loaded_hi = 0;

   always #5 clk = ~clk;

   alu_operand_loader #(.W(W), .DB_CYCLES(DBC)) dut (
      .clk(clk), .rst_n(rst_n), .data_sw(data_sw), .op_sw(op_sw),
      .btn_load(btn_load), .btn_clear(btn_clear), .A(A), .B(B), .op(op),
      .valid(valid), .loaded(loaded), .state_o(state_o)
   );

   // Reference model: raw samples delayed two edges, debounced by a sliding window.
   logic [1:0]   ld_pipe, clr_pipe;
   bit           win[$];
   logic         m_db, m_press;
   logic [W-1:0] m_a, m_b;
   logic [3:0]   m_op;
   logic         m_valid, m_loaded;
   logic [1:0]   m_slot;

   task automatic resetModel();
      ld_pipe = '0; clr_pipe = '0; win.delete();
      m_db = 1'b0; m_press = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_loaded = 1'b0; m_slot = 2'd0;
   endtask

   task automatic modelEdge();
      logic seen_ld, seen_clr, flip;
      seen_ld  = ld_pipe[1];
      seen_clr = clr_pipe[1];
      ld_pipe  = {ld_pipe[0], btn_load};
      clr_pipe = {clr_pipe[0], btn_clear};
      if (seen_clr) begin
         m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0; m_loaded = 1'b0; m_slot = 2'd0;
      end else begin
         m_loaded = 1'b0;
         if (m_press) begin
            case (m_slot)
               2'd0: begin m_a = data_sw; m_slot = 2'd1; end
               2'd1: begin m_b = data_sw; m_slot = 2'd2; end
               2'd2: begin m_op = op_sw; m_slot = 2'd3; m_valid = 1'b1; m_loaded = 1'b1; end
               default: begin m_a = data_sw; m_slot = 2'd1; m_valid = 1'b0; end
            endcase
         end
      end
      win.push_back(seen_ld);
      if (win.size() > DBC) void'(win.pop_front());
      flip = (win.size() == DBC);
      foreach (win[i]) if (win[i] == m_db) flip = 1'b0;
      m_press = flip && !m_db;
      if (flip) m_db = ~m_db;
   endtask

   task automatic checkOutput(input string name, input logic [W-1:0] eA, input logic [W-1:0] eB,
                              input logic [3:0] eOp, input logic eV, input logic eL,
                              input logic [1:0] eS);
      vectors++;
      if (A !== eA || B !== eB || op !== eOp || valid !== eV || loaded !== eL || state_o !== eS) begin
         miscompares++;
         $display("[TB] FAIL %s: got A=%h B=%h op=%h valid=%b loaded=%b state=%b, expected A=%h B=%h op=%h valid=%b loaded=%b state=%b",
                  name, A, B, op, valid, loaded, state_o, eA, eB, eOp, eV, eL, eS);
      end
   endtask

   task automatic checkCount(input string name, input int expCount);
      vectors++;
      if (loaded_hi != expCount) begin
         miscompares++;
         $display("[TB] FAIL %s: loaded high for %0d cycles, expected %0d", name, loaded_hi, expCount);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!rst_n) resetModel();
         else modelEdge();
         #1;
         if (loaded) loaded_hi++;
         checkOutput("model", m_a, m_b, m_op, m_valid, m_loaded, m_slot);
      end
   endtask

   typedef struct {
      string      name;
      logic       clr;
      logic [3:0] d;
      logic [3:0] o;
      logic [3:0] eA;
      logic [3:0] eB;
      logic [3:0] eOp;
      logic       eV;
      logic [1:0] eS;
      int         eLd;
   } vec_t;

   vec_t tbl[10];

   task automatic applyStimulus(input vec_t v);
      loaded_hi = 0;
      if (v.clr) begin
         btn_clear = 1'b1; step(1);
         btn_clear = 1'b0; step(6);
      end else begin
         data_sw = v.d; op_sw = v.o;
         btn_load = 1'b1; step(8);
         btn_load = 1'b0; step(8);
      end
      checkOutput(v.name, v.eA, v.eB, v.eOp, v.eV, 1'b0, v.eS);
      checkCount({v.name, "_loaded"}, v.eLd);
   endtask

   initial begin
      tbl[0] = '{"capA",       1'b0, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 2'b01, 0};
      tbl[1] = '{"capB",       1'b0, 4'h3, 4'h0, 4'h5, 4'h3, 4'h0, 1'b0, 2'b10, 0};
      tbl[2] = '{"capOp",      1'b0, 4'h0, 4'h2, 4'h5, 4'h3, 4'h2, 1'b1, 2'b11, 1};
      tbl[3] = '{"reload",     1'b0, 4'hA, 4'h7, 4'hA, 4'h3, 4'h2, 1'b0, 2'b01, 0};
      tbl[4] = '{"clear1",     1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 0};
      tbl[5] = '{"capA2",      1'b0, 4'h5, 4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 2'b01, 0};
      tbl[6] = '{"clear2",     1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'b00, 0};
      tbl[7] = '{"afterClrA",  1'b0, 4'h7, 4'h1, 4'h7, 4'h0, 4'h0, 1'b0, 2'b01, 0};
      tbl[8] = '{"capB2",      1'b0, 4'h9, 4'h1, 4'h7, 4'h9, 4'h0, 1'b0, 2'b10, 0};
      tbl[9] = '{"capOp2",     1'b0, 4'h4, 4'hF, 4'h7, 4'h9, 4'hF, 1'b1, 2'b11, 1};

      resetModel();
      step(2);
      checkOutput("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      rst_n = 1'b1;
      step(2);

      for (int i = 0; i < 10; i++) applyStimulus(tbl[i]);

      btn_clear = 1'b1; step(1);
      btn_clear = 1'b0; step(4);

      // Capture lands exactly on edge DBC+2 of the press, and holding gives one press.
      data_sw = 4'h5; btn_load = 1'b1;
      step(6);
      checkOutput("edge5_nocap", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      step(1);
      checkOutput("edge6_capA", 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01);
      step(10);
      checkOutput("hold_one_press", 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01);
      btn_load = 1'b0; step(8);

      // Clear takes effect on the third edge that sees it.
      btn_clear = 1'b1; step(1);
      btn_clear = 1'b0; step(1);
      checkOutput("clr_edge1", 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01);
      step(1);
      checkOutput("clr_edge2", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      step(4);

      // Bounce rejection.
      data_sw = 4'h6;
      btn_load = 1'b1; step(3);
      btn_load = 1'b0; step(1);
      btn_load = 1'b1; step(2);
      btn_load = 1'b0; step(2);
      btn_load = 1'b1;
      step(6);
      checkOutput("bounce_nocap", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      step(1);
      checkOutput("bounce_cap", 4'h6, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01);
      step(10);
      checkOutput("bounce_single", 4'h6, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01);
      btn_load = 1'b0; step(8);

      // Clear reaching the FSM in the same cycle as a press in LOAD_B.
      data_sw = 4'h9; btn_load = 1'b1;
      step(4);
      btn_clear = 1'b1; step(1);
      btn_clear = 1'b0; step(2);
      checkOutput("clr_vs_press", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      step(10);
      checkOutput("press_discarded", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      btn_load = 1'b0; step(8);

      // Asynchronous reset from READY, then a held button needs the full debounce.
      for (int i = 0; i < 3; i++) applyStimulus(tbl[i]);
      #2 rst_n = 1'b0;
      #1 checkOutput("async_reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      data_sw = 4'hC; btn_load = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(6);
      checkOutput("post_reset_nocap", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
      step(1);
      checkOutput("post_reset_cap", 4'hC, 4'h0, 4'h0, 1'b0, 1'b0, 2'b01);
      btn_load = 1'b0; step(8);

      // Random button runs and occasional clears against the model.
      for (int s = 0; s < 300; s++) begin
         int len;
         len = $urandom_range(1, 9);
         btn_load = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) begin
            data_sw   = W'($urandom_range(0, 15));
            op_sw     = 4'($urandom_range(0, 15));
            btn_clear = ($urandom_range(0, 15) == 0);
            step(1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
